// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the CPU datapath and the shared RAM/IO port.
// One request in flight; absorbs RAM read latency; decodes LED/switch IO.
module mem_access_ctrl #(
    parameter int          DATA_WIDTH  = 16,
    parameter int          ADDR_WIDTH  = 14,
    parameter logic [15:0] IO_LED_ADDR = 16'hFFFF,
    parameter logic [15:0] IO_SW_ADDR  = 16'hFFFE,
    parameter int          SW_WIDTH    = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [15:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [15:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    input  logic [SW_WIDTH-1:0]   sw_in,
    output logic [7:0]            led_out,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_CAPTURE,
        S_RESPOND
    } state_t;

    typedef enum logic [1:0] {
        R_RAM,
        R_LED,
        R_SW,
        R_OOR
    } region_t;

    state_t                state_q, state_d;
    region_t               region_q, region_d;
    region_t               req_region;
    logic                  we_q, we_d;
    logic [15:0]           mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [7:0]            led_q, led_d;
    logic                  err_q, err_d;
    logic [SW_WIDTH-1:0]   sw_meta_q, sw_sync_q;

    // Address decode of the incoming request into RAM / LED / SW / out-of-range.
    always_comb begin
        req_region = R_OOR;
        if ((req_addr >> ADDR_WIDTH) == 16'd0) begin
            req_region = R_RAM;
        end else if (req_addr == IO_LED_ADDR) begin
            req_region = R_LED;
        end else if (req_addr == IO_SW_ADDR) begin
            req_region = R_SW;
        end
    end

    // Next-state and datapath updates; mem_we defaults low so it lasts one cycle.
    always_comb begin
        state_d     = state_q;
        region_d    = region_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_we_d    = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        led_d       = led_q;
        err_d       = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d    = S_ACCESS;
                    we_d       = req_we;
                    region_d   = req_region;
                    mem_addr_d = req_addr;
                    mem_din_d  = req_wdata;
                    mem_we_d   = req_we & (req_region == R_RAM);
                end
            end
            S_ACCESS: begin
                state_d = we_q ? S_RESPOND : S_CAPTURE;
                if (we_q && region_q == R_LED) begin
                    led_d = mem_din_q[7:0];
                end
                if (region_q == R_OOR) begin
                    err_d = 1'b1;
                end
            end
            S_CAPTURE: begin
                state_d = S_RESPOND;
                unique case (region_q)
                    R_RAM:   rsp_rdata_d = mem_dout;
                    R_LED:   rsp_rdata_d = DATA_WIDTH'(led_q);
                    R_SW:    rsp_rdata_d = DATA_WIDTH'(sw_sync_q);
                    default: rsp_rdata_d = '0;
                endcase
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            region_q    <= R_RAM;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            led_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            region_q    <= region_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_we_q    <= mem_we_d;
            rsp_rdata_q <= rsp_rdata_d;
            led_q       <= led_d;
            err_q       <= err_d;
        end
    end

    // Two-flop synchroniser for the asynchronous board switches.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign req_ready = (state_q == S_IDLE) & ~reset;
    assign rsp_valid = (state_q == S_RESPOND);
    assign rsp_rdata = rsp_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign mem_we    = mem_we_q;
    assign led_out   = led_q;
    assign err       = err_q;

endmodule
